// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
//   Shared types and constants for the decoder/UART blocks.
//   - word                    : 32-bit machine word (prescaler, counters)
//   - UART_OVERSAMPLE_DEFAULT : sample ticks per bit, shared by uart and uart_rx
//   - uart_rx_state_t         : receiver FSM states
//   - maj3                    : 2-of-3 majority vote used by the receiver
// -----------------------------------------------------------------------------
package decoder_pkg;

    typedef logic [31:0] word;

    localparam int UART_OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Prescaled tick generator. While clear is high the counter is held at zero
//   and the prescaler word is captured, so the divide ratio is frozen the
//   moment clear drops. While enabled, tick is high for one clock every
//   prescaler+1 clocks (every clock when prescaler is 0).
//
// Ports:
//   clk_i      in   system clock
//   reset_i    in   synchronous active-low reset
//   clear      in   hold counter at 0 and reload the prescaler
//   enable     in   let the counter run
//   prescaler  in   divide ratio minus one
//   tick       out  one-clock tick (combinational from registered state)
// -----------------------------------------------------------------------------
module uart_baud_tick
    import decoder_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear,
    input  logic enable,
    input  word  prescaler,
    output logic tick
);

    word count_q;
    word prescaler_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            count_q     <= '0;
            prescaler_q <= '0;
        end else if (clear) begin
            count_q     <= '0;
            prescaler_q <= prescaler;
        end else if (enable) begin
            if (count_q == prescaler_q) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign tick = enable && !clear && (count_q == prescaler_q);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver, the receive side of the uart transmitter. Shares the
//   transmitter's prescaler word: one sample tick every prescaler+1 clocks,
//   OVERSAMPLE ticks per bit. Each good frame produces a one-clock valid_o
//   strobe with the byte on data_o, suitable as a fifo write strobe. There is
//   no backpressure.
//
//   Optional build macro: UART_RX_MAJORITY_EN
//     defined   : every sample (start, data, stop) is the 2-of-3 majority of
//                 rx_s at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1
//                 (one extra tick of latency)
//     undefined : single sample at tick OVERSAMPLE/2
//
// Parameters:
//   OVERSAMPLE  sample ticks per bit (even, >= 4)
//   DATA_BITS   data bits per frame, LSB first
//
// Ports:
//   clk_i        in   system clock
//   reset_i      in   synchronous active-low reset
//   prescaler    in   tick every prescaler+1 clocks (latched at frame start)
//   rx           in   serial line, idle high, asynchronous
//   data_o       out  last good byte, held until the next good frame
//   valid_o      out  one-clock pulse per good frame
//   frame_err_o  out  one-clock pulse when the stop bit samples 0
//   busy_o       out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx
    import decoder_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  word                  prescaler,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ_DELAY = 1;
`else
    localparam int MAJ_DELAY = 0;
`endif

    // Tick index (counted from 0) at which each bit is decided. The start
    // bit is decided mid-bit; every later bit exactly one bit period on.
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(OVERSAMPLE / 2 - 1 + MAJ_DELAY);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);

    uart_rx_state_t         state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [BIT_W-1:0]       bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [1:0]             sync_q;
    logic                   rx_s;
    logic                   tick;
    logic                   sample_bit;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    assign rx_s = sync_q[1];

    // Counter is held clear in IDLE, which also keeps reloading the
    // prescaler; the value present on the IDLE->START edge is the one used.
    uart_baud_tick u_tick (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear     (state_q == RX_IDLE),
        .enable    (state_q != RX_IDLE),
        .prescaler (prescaler),
        .tick      (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic             m0_q;
    logic             m1_q;
    logic [CNT_W-1:0] decide_pt;

    assign decide_pt = (state_q == RX_START) ? START_LAST : BIT_LAST;

    // Capture the two ticks before the decision tick; the third vote is the
    // live rx_s on the decision tick itself.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            m0_q <= 1'b1;
            m1_q <= 1'b1;
        end else if (tick) begin
            if (cnt_q == decide_pt - CNT_W'(2)) begin
                m0_q <= rx_s;
            end
            if (cnt_q == decide_pt - CNT_W'(1)) begin
                m1_q <= rx_s;
            end
        end
    end

    assign sample_bit = maj3(m0_q, m1_q, rx_s);
`else
    assign sample_bit = rx_s;
`endif

    // Receiver FSM with registered outputs. cnt_q counts ticks within the
    // current bit; at tick k it holds k-1.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;

            case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (!rx_s) begin
                        state_q <= RX_START;
                        busy_o  <= 1'b1;
                    end
                end

                RX_START: begin
                    if (tick) begin
                        if (cnt_q == START_LAST) begin
                            cnt_q <= '0;
                            if (!sample_bit) begin
                                state_q <= RX_DATA;
                            end else begin
                                // Line was high again mid start bit: glitch.
                                state_q <= RX_IDLE;
                                busy_o  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                RX_DATA: begin
                    if (tick) begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q   <= '0;
                            shift_q <= {sample_bit, shift_q[DATA_BITS-1:1]};
                            if (bit_q == LAST_BIT) begin
                                state_q <= RX_STOP;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                RX_STOP: begin
                    if (tick) begin
                        if (cnt_q == BIT_LAST) begin
                            cnt_q <= '0;
                            if (sample_bit) begin
                                data_o  <= shift_q;
                                valid_o <= 1'b1;
                                state_q <= RX_IDLE;
                                busy_o  <= 1'b0;
                            end else begin
                                frame_err_o <= 1'b1;
                                state_q     <= RX_WAIT_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                RX_WAIT_IDLE: begin
                    // Break or stuck-low line: wait for the line to recover
                    // so the low level is not taken as a new start bit.
                    if (rx_s) begin
                        state_q <= RX_IDLE;
                        busy_o  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= RX_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx. Frames are driven bit by bit from tasks;
//   each expected byte is queued when its frame is driven, and a negedge
//   monitor records every valid_o byte, its cycle and the busy-low count.
// -----------------------------------------------------------------------------
module tb_uart_rx;
    import decoder_pkg::*;

    localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    word        prescaler = '0;
    logic       rx = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       busy_o;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .prescaler   (prescaler),
        .rx          (rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_t[$];
    int         got_b[$];
    int         fall_t[$];
    int         err_cnt = 0;
    int         both_cnt = 0;
    int         busy_low_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    always @(negedge clk) begin
        if (valid_o) begin
            got_q.push_back(data_o);
            got_t.push_back(cyc);
            got_b.push_back(busy_low_cnt);
        end
        if (frame_err_o) err_cnt++;
        if (valid_o && frame_err_o) both_cnt++;
        if (!busy_o) busy_low_cnt++;
    end

    task automatic hold(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int bit_period();
        return (int'(prescaler) + 1) * OS;
    endfunction

    // Pin fall to valid_o: 2 sync + 1 detect + (prescaler+1) per tick for
    // OS/2 start ticks, 9*OS data/stop ticks and the optional majority tick.
    function automatic int latency();
        return 3 + (int'(prescaler) + 1) * (OS / 2 + 9 * OS + MAJ);
    endfunction

    task automatic sb_clear();
        exp_q.delete();
        got_q.delete();
        got_t.delete();
        got_b.delete();
        fall_t.delete();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input bit glitch, input bit expect_ok);
        int bp;
        bp = bit_period();
        fall_t.push_back(cyc);
        if (expect_ok) exp_q.push_back(b);
        rx = 1'b0;
        hold(bp);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (glitch) begin
                hold(bp / 2);
                rx = ~b[i];
                hold(1);
                rx = b[i];
                hold(bp - bp / 2 - 1);
            end else begin
                hold(bp);
            end
        end
        rx = stop_v;
        hold(bp);
    endtask

    task automatic test_reset();
        reset_i = 1'b0;
        rx = 1'b1;
        hold(3);
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data_o); end
        checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", frame_err_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        reset_i = 1'b1;
        hold(2);
    endtask

    task automatic test_single();
        int err0;
        sb_clear();
        err0 = err_cnt;
        prescaler = 32'd0;
        hold(2);
        send_frame(8'h42, 1'b1, 1'b0, 1'b1);
        hold(20);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
        checks++; if (err_cnt != err0) begin failures++; $display("FAIL single_ferr got=%0d exp=%0d", err_cnt, err0); end
        if (got_q.size() > 0 && fall_t.size() > 0) begin
            checks++;
            if (got_t[0] - fall_t[0] != latency()) begin
                failures++;
                $display("FAIL single_latency got=%0d exp=%0d", got_t[0] - fall_t[0], latency());
            end
        end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin failures++; $display("FAIL single_data got=none exp=%h", e); end
            else if (got_q[0] !== e) begin failures++; $display("FAIL single_data got=%h exp=%h", got_q[0], e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        int bp;
        sb_clear();
        prescaler = 32'd3;
        hold(2);
        bp = bit_period();
        send_frame(8'h00, 1'b1, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        hold(2 * bp);
        checks++; if (got_q.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
        if (got_t.size() == 3) begin
            checks++; if (got_t[1] - got_t[0] != 10 * bp) begin failures++; $display("FAIL b2b_spacing1 got=%0d exp=%0d", got_t[1] - got_t[0], 10 * bp); end
            checks++; if (got_t[2] - got_t[1] != 10 * bp) begin failures++; $display("FAIL b2b_spacing2 got=%0d exp=%0d", got_t[2] - got_t[1], 10 * bp); end
            checks++; if (got_t[0] - fall_t[0] != latency()) begin failures++; $display("FAIL b2b_latency got=%0d exp=%0d", got_t[0] - fall_t[0], latency()); end
            // busy low only in the gap between stop decision and next start
            checks++;
            if (got_b[2] - got_b[0] != 2 * (int'(prescaler) + 1) * (OS / 2 - MAJ)) begin
                failures++;
                $display("FAIL b2b_busy_gap got=%0d exp=%0d", got_b[2] - got_b[0], 2 * (int'(prescaler) + 1) * (OS / 2 - MAJ));
            end
        end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", busy_o); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin failures++; $display("FAIL b2b_data got=none exp=%h", e); end
            else if (got_q[0] !== e) begin failures++; $display("FAIL b2b_data got=%h exp=%h", got_q[0], e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    task automatic test_glitch();
        int err0;
        sb_clear();
        err0 = err_cnt;
        prescaler = 32'd0;
        hold(5);
        rx = 1'b0;
        hold(5);
        rx = 1'b1;
        hold(40);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", got_q.size()); end
        checks++; if (err_cnt != err0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=%0d", err_cnt, err0); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", busy_o); end
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        hold(20);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL glitch_next_count got=%0d exp=1", got_q.size()); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin failures++; $display("FAIL glitch_next_data got=none exp=%h", e); end
            else if (got_q[0] !== e) begin failures++; $display("FAIL glitch_next_data got=%h exp=%h", got_q[0], e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    task automatic test_frame_error();
        int err0;
        int bp;
        sb_clear();
        err0 = err_cnt;
        prescaler = 32'd0;
        bp = bit_period();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        hold(100 * bp);
        checks++; if (err_cnt - err0 != 1) begin failures++; $display("FAIL ferr_pulses got=%0d exp=1", err_cnt - err0); end
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", got_q.size()); end
        checks++; if (data_o !== 8'h3C) begin failures++; $display("FAIL ferr_data_hold got=%h exp=3c", data_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL ferr_busy_stuck got=%b exp=1", busy_o); end
        rx = 1'b1;
        hold(2 * bp);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL ferr_busy_release got=%b exp=0", busy_o); end
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        hold(20);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL ferr_next_count got=%0d exp=1", got_q.size()); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin failures++; $display("FAIL ferr_next_data got=none exp=%h", e); end
            else if (got_q[0] !== e) begin failures++; $display("FAIL ferr_next_data got=%h exp=%h", got_q[0], e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    task automatic test_reset_midframe();
        int err0;
        int bp;
        logic [7:0] b;
        sb_clear();
        err0 = err_cnt;
        prescaler = 32'd0;
        bp = bit_period();
        b = 8'h77;
        rx = 1'b0;
        hold(bp);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            hold(bp);
        end
        rx = b[4];
        hold(bp / 2);
        reset_i = 1'b0;
        hold(1);
        reset_i = 1'b1;
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", data_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
        // the sender abandons the frame too; line returns to idle
        rx = 1'b1;
        hold(12 * bp);
        checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rstmid_valid got=%0d exp=0", got_q.size()); end
        checks++; if (err_cnt != err0) begin failures++; $display("FAIL rstmid_ferr got=%0d exp=%0d", err_cnt, err0); end
        checks++; if (data_o !== 8'h00) begin failures++; $display("FAIL rstmid_data_after got=%h exp=00", data_o); end
        send_frame(8'h12, 1'b1, 1'b0, 1'b1);
        hold(20);
        checks++; if (got_q.size() != 1) begin failures++; $display("FAIL rstmid_next_count got=%0d exp=1", got_q.size()); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin failures++; $display("FAIL rstmid_next_data got=none exp=%h", e); end
            else if (got_q[0] !== e) begin failures++; $display("FAIL rstmid_next_data got=%h exp=%h", got_q[0], e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    task automatic test_loopback(input int n, input bit glitch);
        int err0;
        int cnt_exp;
        sb_clear();
        err0 = err_cnt;
        prescaler = 32'd2;
        hold(2);
        for (int i = 0; i < n; i++) begin
            send_frame(8'(i), 1'b1, glitch, 1'b1);
        end
        hold(2 * bit_period());
        cnt_exp = n;
        checks++; if (got_q.size() != cnt_exp) begin failures++; $display("FAIL loop_count glitch=%0d got=%0d exp=%0d", glitch, got_q.size(), cnt_exp); end
        checks++; if (err_cnt != err0) begin failures++; $display("FAIL loop_ferr glitch=%0d got=%0d exp=%0d", glitch, err_cnt, err0); end
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin failures++; $display("FAIL loop_data glitch=%0d got=none exp=%h", glitch, e); end
            else if (got_q[0] !== e) begin failures++; $display("FAIL loop_data glitch=%0d got=%h exp=%h", glitch, got_q[0], e); end
            if (got_q.size() > 0) void'(got_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_midframe();
        test_loopback(64, 1'b0);
`ifdef UART_RX_MAJORITY_EN
        test_loopback(32, 1'b1);
`endif
        checks++;
        if (both_cnt != 0) begin
            failures++;
            $display("FAIL valid_and_ferr_together got=%0d exp=0", both_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
